// File: rtl/ntt_sched.sv
// Address/twiddle sequencer for a single Kyber butterfly: walks the 7 layers of a
// 256-point forward or inverse NTT, one butterfly per cycle, and replays the addresses as writes.
module ntt_sched #(
   parameter int LAT = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic       i_inv,
   output logic       o_busy,
   output logic       o_done,
   output logic [1:0] o_bf_mode,
   output logic       o_rd_en,
   output logic [7:0] o_rd_addr_a,
   output logic [7:0] o_rd_addr_b,
   output logic [6:0] o_tw_addr,
   output logic       o_wr_en,
   output logic [7:0] o_wr_addr_a,
   output logic [7:0] o_wr_addr_b
);

   localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [DW-1:0] DLAST = DW'(LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [6:0]      r_i, w_i_nxt;
   logic [2:0]      r_l, w_l_nxt;
   logic            r_inv, w_inv_nxt;
   logic [DW-1:0]   r_dcnt, w_dcnt_nxt;
   logic            w_run_nxt, w_busy_nxt;
   logic [3:0]      w_s;
   logic [7:0]      w_i8, w_len, w_g, w_o, w_a, w_b;
   logic [6:0]      w_tw;
   logic [16:0]     r_dly [LAT];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_i     <= 7'd0;
         r_l     <= 3'd0;
         r_inv   <= 1'b0;
         r_dcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_i     <= w_i_nxt;
         r_l     <= w_l_nxt;
         r_inv   <= w_inv_nxt;
         r_dcnt  <= w_dcnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_i_nxt     = r_i;
      w_l_nxt     = r_l;
      w_inv_nxt   = r_inv;
      w_dcnt_nxt  = r_dcnt;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_nxt = S_RUN;
               w_inv_nxt   = i_inv;
               w_l_nxt     = 3'd0;
               w_i_nxt     = 7'd0;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            if (r_i == 7'd127) begin
               w_state_nxt = S_DRAIN;
               w_i_nxt     = 7'd0;
               w_dcnt_nxt  = '0;
            end else begin
               w_i_nxt = r_i + 7'd1;
            end
         end
         // Read-free gap so the previous layer's results land before the next layer reads them
         S_DRAIN: begin
            if (r_dcnt == DLAST) begin
               if (r_l == 3'd6) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_RUN;
                  w_l_nxt     = r_l + 3'd1;
               end
            end else begin
               w_dcnt_nxt = r_dcnt + DW'(1);
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from next-state values; w_s = log2(len), so g/o are shift/mask
   always_comb begin
      w_run_nxt  = (w_state_nxt == S_RUN);
      w_busy_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
      w_s        = w_inv_nxt ? (4'd1 + {1'b0, w_l_nxt}) : (4'd7 - {1'b0, w_l_nxt});
      w_i8       = {1'b0, w_i_nxt};
      w_len      = 8'd1 << w_s;
      w_g        = w_i8 >> w_s;
      w_o        = w_i8 & (w_len - 8'd1);
      w_a        = (w_g << (w_s + 4'd1)) | w_o;
      w_b        = w_a | w_len;
      // INTT: 256/len wraps to 0 at len=2 in 7 bits, so 0-1-g still yields 127-g
      w_tw       = w_inv_nxt ? ((7'd1 << (4'd8 - w_s)) - 7'd1 - w_g[6:0])
                             : ((7'd1 << (4'd7 - w_s)) + w_g[6:0]);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_bf_mode   <= 2'b11;
         o_rd_en     <= 1'b0;
         o_rd_addr_a <= 8'd0;
         o_rd_addr_b <= 8'd0;
         o_tw_addr   <= 7'd0;
      end else begin
         o_busy      <= w_busy_nxt;
         o_done      <= (w_state_nxt == S_DONE);
         o_bf_mode   <= w_busy_nxt ? {1'b0, w_inv_nxt} : 2'b11;
         o_rd_en     <= w_run_nxt;
         o_rd_addr_a <= w_run_nxt ? w_a : 8'd0;
         o_rd_addr_b <= w_run_nxt ? w_b : 8'd0;
         o_tw_addr   <= w_run_nxt ? w_tw : 7'd0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < LAT; k++) r_dly[k] <= 17'd0;
      end else begin
         r_dly[0] <= {o_rd_en, o_rd_addr_a, o_rd_addr_b};
         for (int k = 1; k < LAT; k++) r_dly[k] <= r_dly[k-1];
      end
   end

   assign o_wr_en     = r_dly[LAT-1][16];
   assign o_wr_addr_a = r_dly[LAT-1][15:8];
   assign o_wr_addr_b = r_dly[LAT-1][7:0];

endmodule

// File: tb/tb_ntt_sched.sv
// Scoreboard bench for ntt_sched: per-cycle timing model plus queued expected
// read/write addresses computed with plain division/modulo.
module tb_ntt_sched;
   localparam int LAT = 4;
   localparam int P   = 128 + LAT;
   localparam int TOT = 7 * P + 1;

   logic       clk = 1'b0;
   logic       i_rst, i_start, i_inv;
   logic       o_busy, o_done, o_rd_en, o_wr_en;
   logic [1:0] o_bf_mode;
   logic [7:0] o_rd_addr_a, o_rd_addr_b, o_wr_addr_a, o_wr_addr_b;
   logic [6:0] o_tw_addr;

   int n_checks = 0;
   int n_err    = 0;
   int cnt_rd, cnt_wr, cnt_busy, cnt_done;
   logic [22:0] rdq [$];
   logic [15:0] wrq [$];

   ntt_sched #(.LAT(LAT)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_inv(i_inv),
      .o_busy(o_busy), .o_done(o_done), .o_bf_mode(o_bf_mode),
      .o_rd_en(o_rd_en), .o_rd_addr_a(o_rd_addr_a), .o_rd_addr_b(o_rd_addr_b),
      .o_tw_addr(o_tw_addr), .o_wr_en(o_wr_en),
      .o_wr_addr_a(o_wr_addr_a), .o_wr_addr_b(o_wr_addr_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_expected(input bit inv);
      int len, g, o, a, b, tw;
      rdq.delete();
      wrq.delete();
      for (int l = 0; l < 7; l++) begin
         for (int i = 0; i < 128; i++) begin
            len = inv ? (2 << l) : (128 >> l);
            g   = i / len;
            o   = i % len;
            a   = 2 * len * g + o;
            b   = a + len;
            tw  = inv ? (256 / len - 1 - g) : (128 / len + g);
            rdq.push_back({a[7:0], b[7:0], tw[6:0]});
            wrq.push_back({a[7:0], b[7:0]});
         end
      end
   endtask

   task automatic check_reset_outputs();
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_mode", o_bf_mode, 3);
      chk("rst_rd_en", o_rd_en, 0);
      chk("rst_wr_en", o_wr_en, 0);
      chk("rst_addrs", {o_rd_addr_a, o_rd_addr_b, o_tw_addr, o_wr_addr_a, o_wr_addr_b}, 0);
   endtask

   task automatic spot(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [6:0] tw);
      chk(tag, {o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr}, {1'b1, a, b, tw});
   endtask

   task automatic check_cycle(input int c, input bit inv);
      int  r, l, cw;
      bit  rd_e, wr_e, busy_e, done_e;
      logic [22:0] er;
      logic [15:0] ew;
      r      = (c - 1) % P;
      l      = (c - 1) / P;
      rd_e   = (l < 7) && (r < 128);
      cw     = c - 1 - LAT;
      wr_e   = (cw >= 0) && (cw / P < 7) && (cw % P < 128);
      busy_e = (c <= 7 * P);
      done_e = (c == TOT);
      chk($sformatf("rd_en@%0d", c), o_rd_en, rd_e);
      chk($sformatf("wr_en@%0d", c), o_wr_en, wr_e);
      chk($sformatf("busy@%0d", c), o_busy, busy_e);
      chk($sformatf("done@%0d", c), o_done, done_e);
      chk($sformatf("mode@%0d", c), o_bf_mode, busy_e ? {1'b0, inv} : 2'b11);
      if (rd_e) begin
         chk($sformatf("rdq_avail@%0d", c), rdq.size() > 0, 1);
         if (rdq.size() > 0) begin
            er = rdq.pop_front();
            chk($sformatf("rd_addr@%0d", c), {o_rd_addr_a, o_rd_addr_b, o_tw_addr}, er);
         end
      end
      if (wr_e) begin
         chk($sformatf("wrq_avail@%0d", c), wrq.size() > 0, 1);
         if (wrq.size() > 0) begin
            ew = wrq.pop_front();
            chk($sformatf("wr_addr@%0d", c), {o_wr_addr_a, o_wr_addr_b}, ew);
         end
      end
      if (!inv && c == 1)              spot("ntt_l0_first", 8'd0, 8'd128, 7'd1);
      if (!inv && c == 128)            spot("ntt_l0_last", 8'd127, 8'd255, 7'd1);
      if (!inv && c == 1 + P)          spot("ntt_l1_first", 8'd0, 8'd64, 7'd2);
      if (!inv && c == 1 + 6 * P)      spot("ntt_l6_b0", 8'd0, 8'd2, 7'd64);
      if (!inv && c == 2 + 6 * P)      spot("ntt_l6_b1", 8'd1, 8'd3, 7'd64);
      if (!inv && c == 3 + 6 * P)      spot("ntt_l6_b2", 8'd4, 8'd6, 7'd65);
      if (!inv && c == 128 + 6 * P)    spot("ntt_l6_last", 8'd253, 8'd255, 7'd127);
      if (inv && c == 1)               spot("intt_l0_first", 8'd0, 8'd2, 7'd127);
      if (inv && c == 128)             spot("intt_l0_last", 8'd253, 8'd255, 7'd64);
      if (inv && c == 6 + 6 * P)       spot("intt_l6_b5", 8'd5, 8'd133, 7'd1);
      cnt_rd   += int'(o_rd_en);
      cnt_wr   += int'(o_wr_en);
      cnt_busy += int'(o_busy);
      cnt_done += int'(o_done);
   endtask

   // Called just after an edge with the DUT idle; start is driven in the current cycle (cycle 0)
   task automatic run_one(input bit inv, input bit pulses, input int abort_c);
      push_expected(inv);
      cnt_rd = 0; cnt_wr = 0; cnt_busy = 0; cnt_done = 0;
      i_inv   = inv;
      i_start = 1'b1;
      for (int c = 1; c <= TOT; c++) begin
         @(posedge clk); #1;
         check_cycle(c, inv);
         i_start = pulses && (c == 50 || c == TOT);
         i_inv   = 1'($urandom_range(0, 1));
         if (c == abort_c) begin
            i_rst = 1'b1;
            return;
         end
      end
      chk("rd_pulses", cnt_rd, 896);
      chk("wr_pulses", cnt_wr, 896);
      chk("busy_cycles", cnt_busy, 924);
      chk("done_pulses", cnt_done, 1);
      chk("rdq_drained", rdq.size(), 0);
      chk("wrq_drained", wrq.size(), 0);
   endtask

   initial begin
      i_rst   = 1'b1;
      i_start = 1'b0;
      i_inv   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      i_rst = 1'b0;
      @(posedge clk); #1;

      // NTT with stray starts at cycles 50 and 925
      run_one(1'b0, 1'b1, 0);
      @(posedge clk); #1;
      chk("idle926_busy", o_busy, 0);
      chk("idle926_rd_en", o_rd_en, 0);
      chk("idle926_mode", o_bf_mode, 3);
      // start in cycle 926: first INTT read must appear in cycle 927
      run_one(1'b1, 1'b0, 0);
      @(posedge clk); #1;

      // Reset asserted in cycle 300 of an NTT
      run_one(1'b0, 1'b0, 300);
      @(posedge clk); #1;
      i_rst = 1'b0;
      check_reset_outputs();
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk($sformatf("post_rst_wr_en%0d", k), o_wr_en, 0);
         chk($sformatf("post_rst_rd_en%0d", k), o_rd_en, 0);
      end
      run_one(1'b0, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end
endmodule

// File: doc/ntt_sched.md
# ntt_sched

Sequencer for the single 16-bit Kyber butterfly datapath. On a start pulse it walks all 7 layers of a 256-point forward NTT or inverse NTT. Every cycle it issues one butterfly's coefficient-RAM read addresses, twiddle-ROM address and butterfly mode. It then replays the same addresses as write-back commands after the datapath latency. It sits between the top-level command interface and the coefficient RAM / twiddle ROM / butterfly.

## Interface
- LAT, default 4: cycles from rd_en assertion to the matching butterfly result being valid at c/d, including RAM read; must be >= 1.
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; honoured only in IDLE
- inv  in  1  0 = forward NTT, 1 = inverse NTT; sampled with start
- busy  out  1  high from first read cycle through last write cycle
- done  out  1  one-cycle pulse after last write
- bf_mode  out  2  to butterfly mode: 2'b00 NTT, 2'b01 INTT, 2'b11 idle
- rd_en  out  1  read strobe for both RAM ports
- rd_addr_a, rd_addr_b  out  8 each  coefficient indices j and j+len
- tw_addr  out  7  twiddle (zeta) ROM index
- wr_en  out  1  write strobe, rd_en delayed LAT cycles
- wr_addr_a, wr_addr_b  out  8 each  rd_addr_a/b delayed LAT cycles

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 latches inv, clears layer counter L=0 and butterfly counter i=0, goes to RUN. start with busy high, or in DRAIN/DONE, is ignored.
- RUN: rd_en=1 each cycle; i increments 0..127; at i=127 goes to DRAIN and resets i=0.
- DRAIN: rd_en=0 for exactly LAT cycles, which prevents read-after-write hazards across layers. Afterwards: if L<6, L++ and return to RUN; if L=6, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Layer length len: NTT len = 128>>L (128 down to 2); INTT len = 2<<L (2 up to 128).
- Per butterfly: g = i / len, o = i % len; rd_addr_a = 2*len*g + o; rd_addr_b = rd_addr_a + len. Both computed by shift/mask only, no divider.
- Twiddle: NTT tw_addr = 128/len + g; INTT tw_addr = 256/len - 1 - g. This gives zeta indices 1..127 in Kyber order; INTT walks k from 127 downward. Index 0 is never issued.
- bf_mode: 2'b00 (inv=0) or 2'b01 (inv=1) held constant for the whole busy interval including DRAIN; 2'b11 in IDLE and DONE.
- Write path: LAT-deep shift register carries {rd_en, rd_addr_a, rd_addr_b}. Its outputs are wr_en, wr_addr_a, wr_addr_b, so results write in place.
- Reset values: busy=0, done=0, bf_mode=2'b11, rd_en=0, wr_en=0, all address outputs 0, shift register cleared, state IDLE.
- Reset mid-run: the next cycle is IDLE with no residual wr_en from the delay line.

## Timing
- All outputs registered. start sampled at edge 0; first rd_en in cycle 1.
- Layer L reads occupy cycles 1+L*(128+LAT) .. 128+L*(128+LAT).
- Writes for layer L occupy cycles 1+LAT+L*(128+LAT) .. 128+LAT+L*(128+LAT). The last write of a layer lands one cycle before the next layer's first read.
- busy high for cycles 1 .. 7*(128+LAT); done in cycle 7*(128+LAT)+1, with busy=0. Total latency 7*(128+LAT)+1 cycles (LAT=4: done at cycle 925).
- start asserted in the DONE cycle is ignored; start in the following IDLE cycle is accepted, giving back-to-back transforms with one idle cycle.
- inv changes while busy have no effect.

## Test plan
- NTT, LAT=4: reads cycles 1..128 give addr_a 0..127, addr_b 128..255, tw_addr=1. Layer 6 first three butterflies give (0,2,tw 64), (1,3,tw 64), (4,6,tw 65); last gives (253,255,tw 127).
- INTT: layer 0 first butterfly (0,2,tw 127), last (253,255,tw 64). Layer 6 gives (i, i+128, tw 1); bf_mode=01 throughout busy.
- Write replay: wr_en/wr_addr match rd_en/rd_addr delayed exactly 4 cycles. No rd_en in cycles 129..132. Layer-1 first read (0,64,tw 2) at cycle 133.
- Full run: busy high for exactly 924 cycles, single done pulse at cycle 925, exactly 896 rd_en and 896 wr_en pulses.
- start pulsed at cycles 50 and 925 during a run: no effect. start at 926 begins a new transform with first read at 927.
- rst asserted at cycle 300: next cycle all outputs at reset values and no wr_en for the following 4 cycles. A subsequent start produces an unchanged full sequence.
